// File: rtl/adder_result_accumulator_pkg.sv
// rtl/adder_result_accumulator_pkg.sv - shared FSM encoding and adder result width
package adder_result_accumulator_pkg;

  localparam int SUM_W = 4;
  localparam int RES_W = SUM_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Carry-out is the MSB of the upstream adder's full 5-bit result.
  function automatic logic [RES_W-1:0] adder_result(input logic [SUM_W-1:0] s, input logic c);
    return {c, s};
  endfunction

endpackage

// File: rtl/adder_result_accumulator_sample_counter.sv
// rtl/adder_result_accumulator_sample_counter.sv - per-run sample counter with terminal flag
module sample_counter #(
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flags the sample whose acceptance completes the run.
  assign terminal = (count == LAST);

endmodule

// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - sums N_SAMPLES 5-bit adder results with sticky wrap flag
module adder_result_accumulator
  import adder_result_accumulator_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_W-1:0]     sum_in,
  input  logic                 cout_in,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  state_t          state;
  state_t          state_nxt;
  logic            run_start;
  logic            accept;
  logic            last;
  logic [ACC_W:0]  acc_sum;
  logic [RES_W-1:0] res;

  assign run_start = (state == ST_IDLE) && start;
  assign accept    = (state == ST_ACC) && in_valid;

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  sample_counter #(
    .N_SAMPLES (N_SAMPLES)
  ) u_sample_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (run_start),
    .en       (accept),
    .terminal (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start during the DONE handshake is dropped: only IDLE looks at start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ACC;
      ST_ACC:  if (accept && last) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign res     = adder_result(sum_in, cout_in);
  assign acc_sum = {1'b0, acc_out} + {{(ACC_W + 1 - RES_W){1'b0}}, res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out <= '0;
      ovf     <= 1'b0;
    end else if (run_start) begin
      acc_out <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      acc_out <= acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb/tb_adder_result_accumulator.sv - self-checking bench for adder_result_accumulator
module tb_adder_result_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] sum_in = 4'd0;
  logic       cout_in = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready8, out_valid8, ovf8, busy8;
  logic [7:0] acc8;
  logic       in_ready6, out_valid6, ovf6, busy6;
  logic [5:0] acc6;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference: true integer run total; wrapped value and sticky flag follow from it.
  int m_state;
  int m_cnt;
  int m_total;

  always #5 clk = ~clk;

  adder_result_accumulator #(.N_SAMPLES(8), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready8),
    .sum_in(sum_in), .cout_in(cout_in), .acc_out(acc8), .ovf(ovf8),
    .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8)
  );

  adder_result_accumulator #(.N_SAMPLES(8), .ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready6),
    .sum_in(sum_in), .cout_in(cout_in), .acc_out(acc6), .ovf(ovf6),
    .out_valid(out_valid6), .out_ready(out_ready), .busy(busy6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_total = 0;
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_cnt = 0; m_total = 0; end
        1: if (in_valid) begin
             m_total += int'({cout_in, sum_in});
             m_cnt++;
             if (m_cnt == 8) m_state = 2;
           end
        default: if (out_ready) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m8_in_ready",  32'(in_ready8),  32'(m_state == 1));
      chk("m8_out_valid", 32'(out_valid8), 32'(m_state == 2));
      chk("m8_busy",      32'(busy8),      32'(m_state != 0));
      chk("m8_acc",       32'(acc8),       32'(m_total % 256));
      chk("m8_ovf",       32'(ovf8),       32'(m_total >= 256));
      chk("m6_out_valid", 32'(out_valid6), 32'(m_state == 2));
      chk("m6_in_ready",  32'(in_ready6),  32'(m_state == 1));
      chk("m6_busy",      32'(busy6),      32'(m_state != 0));
      chk("m6_acc",       32'(acc6),       32'(m_total % 64));
      chk("m6_ovf",       32'(ovf6),       32'(m_total >= 64));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds n samples; in_valid drops for gap_len cycles before sample gap_at.
  task automatic feed(input int n, input logic [3:0] s, input logic c,
                      input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          chk("gap_in_ready", 32'(in_ready8), 32'd1);
        end
      end
      in_valid = 1'b1;
      sum_in   = s;
      cout_in  = c;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid8), 32'd0);
    chk("drain_busy",      32'(busy8),      32'd0);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_acc", 32'(acc8), 32'd0);
    chk("reset_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 8 back-to-back samples of 18
    pulse_start();
    feed(8, 4'b0010, 1'b1, -1, 0);
    chk("t1_out_valid", 32'(out_valid8), 32'd1);
    chk("t1_acc8", 32'(acc8), 32'h90);
    chk("t1_ovf8", 32'(ovf8), 32'd0);
    chk("t1_acc6", 32'(acc6), 32'd16);
    chk("t1_ovf6", 32'(ovf6), 32'd1);
    @(negedge clk);
    chk("t1_ovf6_held", 32'(ovf6), 32'd1);
    drain();

    // 8 samples of 30 with a 3-cycle stall between 4th and 5th
    pulse_start();
    feed(8, 4'b1110, 1'b1, 4, 3);
    chk("t2_acc8", 32'(acc8), 32'hF0);
    chk("t2_ovf8", 32'(ovf8), 32'd0);
    drain();

    // DONE held by out_ready=0 for 5 cycles; 8 x 5 = 40
    pulse_start();
    feed(8, 4'd5, 1'b0, -1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(out_valid8), 32'd1);
      chk("t4_hold_acc",   32'(acc8),       32'd40);
      @(negedge clk);
    end
    drain();
    chk("t4_idle_acc_kept", 32'(acc8), 32'd40);

    // Asynchronous reset after 3 of 8 accepts
    pulse_start();
    feed(3, 4'd7, 1'b0, -1, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_acc",       32'(acc8),       32'd0);
    chk("t5_rst_in_ready",  32'(in_ready8),  32'd0);
    chk("t5_rst_busy",      32'(busy8),      32'd0);
    chk("t5_rst_out_valid", 32'(out_valid8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    feed(8, 4'd1, 1'b0, -1, 0);
    chk("t5_acc8", 32'(acc8), 32'd8);
    chk("t5_ovf8", 32'(ovf8), 32'd0);
    drain();

    // in_valid in IDLE, start in ACC, start with DONE handshake: all ignored
    in_valid = 1'b1; sum_in = 4'd9; cout_in = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("t6_idle_busy", 32'(busy8), 32'd0);
    pulse_start();
    feed(3, 4'd3, 1'b0, -1, 0);
    start = 1'b1;
    feed(5, 4'd3, 1'b0, -1, 0);
    start = 1'b0;
    chk("t6_acc8", 32'(acc8), 32'd24);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t6_no_restart", 32'(busy8), 32'd0);
    chk("t6_acc_kept", 32'(acc8), 32'd24);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_result_accumulator.md
ADDER_RESULT_ACCUMULATOR -- requirements
Module: adder_result_accumulator

Interface
REQ-001 Parameter N_SAMPLES, default 8: number of adder results summed per run; legal range 2..255.
REQ-002 Parameter ACC_W, default 8: accumulator width in bits; legal range 5..16.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  begin a new run; honoured only in IDLE.
REQ-007 in_valid  input  1  sum_in/cout_in hold a valid adder result.
REQ-008 in_ready  output  1  block accepts a result this cycle.
REQ-009 sum_in  input  4  upstream 4-bit adder sum S.
REQ-010 cout_in  input  1  upstream adder carry-out Cout.
REQ-011 acc_out  output  ACC_W  accumulated total of the run.
REQ-012 ovf  output  1  sticky flag: the accumulator wrapped during the run.
REQ-013 out_valid  output  1  acc_out/ovf hold a completed result.
REQ-014 out_ready  input  1  downstream takes the result.
REQ-015 busy  output  1  high in ACC and DONE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACC, DONE.
REQ-017 IDLE: start=1 -> next cycle ACC, with acc_out=0, ovf=0, sample count=0; start=0 -> stay in IDLE, acc_out/ovf keep previous run values.
REQ-018 in_ready SHALL be 1 exactly when state=ACC; a result is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-019 Each accepted result SHALL contribute the 5-bit value {cout_in,sum_in} (0..31), zero-extended to ACC_W+1 bits, added to acc_out.
REQ-020 acc_out SHALL take the low ACC_W bits of the sum (wrap mod 2^ACC_W); a carry out of bit ACC_W-1 sets ovf, which stays 1 until the next start or rst.
REQ-021 in_valid=0 in ACC SHALL leave acc_out, ovf and the count unchanged; stalls of any length are legal.
REQ-022 On acceptance of the N_SAMPLES-th result, the FSM SHALL enter DONE on that same edge; out_valid=1 from the following cycle (1-cycle latency from the final accept).
REQ-023 DONE: out_valid=1, acc_out and ovf held stable; out_valid=1 and out_ready=1 on an edge -> IDLE; out_ready=0 -> stay in DONE indefinitely.
REQ-024 start SHALL be ignored in ACC and DONE; start asserted together with the DONE handshake SHALL be ignored (IDLE entered, no new run started).
REQ-025 in_valid while not in ACC SHALL be ignored, with no state change.
REQ-026 out_valid SHALL be 0 in IDLE and ACC.
REQ-027 busy SHALL be 1 when state is ACC or DONE, 0 in IDLE.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force state=IDLE, acc_out=0, ovf=0, count=0, in_ready=0, out_valid=0, busy=0.
REQ-029 rst asserted mid-run (ACC or DONE) SHALL discard the partial or pending result; no output handshake follows.
REQ-030 After rst deasserts, the first start SHALL behave as in REQ-017.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE/ACC/DONE) and the constant for the adder result width (5 bits = 4 sum + 1 carry).
REQ-032 Sample counting SHALL be a sub-module, sample_counter: width $clog2(N_SAMPLES+1), with clear, enable and a terminal flag at N_SAMPLES-1.
REQ-033 All sequential logic SHALL be clocked on clk's rising edge, with rst in the sensitivity list.

Verification
REQ-034 Defaults; start; 8 back-to-back results of sum=0010, cout=1 (value 18) -> out_valid 1 cycle after the 8th accept, acc_out=0x90 (144), ovf=0.
REQ-035 Defaults; 8 results of sum=1110, cout=1 (value 30), with in_valid low for 3 cycles between samples 4 and 5 -> acc_out=0xF0 (240), ovf=0, and in_ready high throughout ACC.
REQ-036 ACC_W=6; 8 results of value 18 -> acc_out=16 (144 mod 64), ovf=1 and held through DONE.
REQ-037 Defaults; a run completes, with out_ready held 0 for 5 cycles -> out_valid and acc_out stable for those 5 cycles; out_ready=1 -> IDLE next cycle, out_valid=0, busy=0.
REQ-038 rst pulsed after 3 of 8 accepts -> all outputs 0 at once; a new start plus 8 results of value 1 -> acc_out=8, ovf=0.
REQ-039 start pulsed during ACC and in_valid pulsed in IDLE -> no effect on count, acc_out or state; the final result still matches the expected sum.
